// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizing for the sram_ctrl request/response SRAM front end.
package sram_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 10;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned RD_LAT         = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        RSP     = 3'd4
    } sram_ctrl_state_e;

endpackage

// File: rtl/sram_ctrl_iobuf.sv
// Tristate driver for the shared SRAM data bus; the controller only drives during writes.
module sram_ctrl_iobuf #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  drive_en,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic [DATA_WIDTH-1:0] din,
    inout  wire  [DATA_WIDTH-1:0] sram_data
);

    assign sram_data = drive_en ? dout : 'z;
    assign din       = sram_data;

endmodule

// File: rtl/sram_ctrl.sv
// Converts a valid/ready request stream into single-port SRAM bus cycles and
// returns read data on a valid/ready response port.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic                  sram_oe,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data
);

    sram_ctrl_state_e      state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] bus_din;
    logic                  drive_en;
    logic                  accept;

    // Gated by rstn so the handshake is closed while reset is held.
    assign req_ready = rstn && ((state_q == IDLE) || (state_q == WR));
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, WR: begin
                if (accept) state_d = req_we ? WR : RD_ADDR;
                else        state_d = IDLE;
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: state_d = RSP;
            RSP:     state_d = rsp_ready ? IDLE : RSP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= req_addr;
                if (req_we) wdata_q <= req_wdata;
            end
            if (state_q == RD_DATA) rdata_q <= bus_din;
        end
    end

    assign sram_cs   = (state_q == WR) || (state_q == RD_ADDR) || (state_q == RD_DATA);
    assign sram_we   = (state_q == WR);
    assign sram_oe   = (state_q == RD_ADDR) || (state_q == RD_DATA);
    assign sram_addr = addr_q;
    assign drive_en  = (state_q == WR);
    assign rsp_valid = (state_q == RSP);
    assign rsp_rdata = rdata_q;

    sram_ctrl_iobuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_iobuf (
        .drive_en  (drive_en),
        .dout      (wdata_q),
        .din       (bus_din),
        .sram_data (sram_data)
    );

endmodule
